// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared definitions for the operand-stack controller.
//   - default entry width / RAM address width
//   - 2-bit FSM state encoding, also exported on the debug state port
package stack_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH_WR  = 2'd1,
    ST_POP_RD   = 2'd2,
    ST_POP_DONE = 2'd3
  } stack_state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response bundle between the main controller
// (master) and the stack controller (slave).
//   push_req  : push request, held until accepted
//   push_data : value to push, sampled on accept
//   pop_req   : pop request, held until accepted
//   ready     : high only while the stack controller is idle
//   pop_data  : last popped value, held until the next pop completes
//   pop_valid : one-cycle pulse when pop_data is new
// Handshake: a request is accepted in the cycle where req & ready are both
// high at the rising clock edge; push wins when both requests are high, and
// the losing pop stays asserted until it is accepted at a later idle cycle.
interface stack_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic              push_req;
  logic [DATA_W-1:0] push_data;
  logic              pop_req;
  logic              ready;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;

  modport master (
    output push_req, push_data, pop_req,
    input  ready, pop_data, pop_valid
  );

  modport slave (
    input  push_req, push_data, pop_req,
    output ready, pop_data, pop_valid
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: operand-stack sequencer. Owns the stack pointer (count) and
// drives an external single-port synchronous RAM (read data valid one cycle
// after the address).
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   ctl            : push/pop request bundle (slave side)
//   clear_i        : synchronous stack flush, aborts any in-flight operation
//   clr_err_i      : clears sticky error flags
//   count_o        : number of entries, 0..2^ADDR_W
//   full_o/empty_o : count == 2^ADDR_W / count == 0
//   ovf_err_o      : sticky, push attempted while full
//   unf_err_o      : sticky, pop attempted while empty
//   mem_*          : RAM address / write data / write enable / read data
//   state_o        : current FSM state (debug)
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  stack_ctrl_if.slave       ctl,
  input  logic              clear_i,
  input  logic              clr_err_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_err_o,
  output logic              unf_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output stack_state_e      state_o
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(1) << ADDR_W;

  stack_state_e      state_q;
  logic [ADDR_W:0]   count_q;
  logic              ready_q;
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;

  logic              full, empty;
  logic              push_acc, pop_acc;
  logic [ADDR_W:0]   count_dec;

  assign full      = (count_q == DEPTH);
  assign empty     = (count_q == '0);
  assign count_dec = count_q - 1'b1;

  // Push has priority; a pop is only accepted when no push is pending.
  assign push_acc = ctl.push_req & ready_q;
  assign pop_acc  = ctl.pop_req & ready_q & ~ctl.push_req;

  // A flag raised in the same cycle as clr_err_i stays set. A clear pulse
  // blocks acceptance, so it also blocks raising an error.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err_i) | (push_acc & full  & ~clear_i);
    unf_d = (unf_q & ~clr_err_i) | (pop_acc  & empty & ~clear_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      ready_q     <= 1'b1;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      pop_valid_q <= 1'b0;
      if (clear_i) begin
        state_q     <= ST_IDLE;
        count_q     <= '0;
        ready_q     <= 1'b1;
        mem_addr_q  <= '0;
        mem_wdata_q <= '0;
        mem_we_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (push_acc && !full) begin
              mem_addr_q  <= count_q[ADDR_W-1:0];
              mem_wdata_q <= ctl.push_data;
              mem_we_q    <= 1'b1;
              ready_q     <= 1'b0;
              state_q     <= ST_PUSH_WR;
            end else if (pop_acc && !empty) begin
              // Pointer drops immediately; the read uses the new value.
              count_q    <= count_dec;
              mem_addr_q <= count_dec[ADDR_W-1:0];
              ready_q    <= 1'b0;
              state_q    <= ST_POP_RD;
            end
          end
          ST_PUSH_WR: begin
            count_q     <= count_q + 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
          ST_POP_RD: begin
            // RAM latches the address at this edge; data arrives next cycle.
            mem_addr_q <= '0;
            state_q    <= ST_POP_DONE;
          end
          ST_POP_DONE: begin
            pop_data_q  <= mem_rdata_i;
            pop_valid_q <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ctl.ready     = ready_q;
  assign ctl.pop_data  = pop_data_q;
  assign ctl.pop_valid = pop_valid_q;
  assign count_o       = count_q;
  assign full_o        = full;
  assign empty_o       = empty;
  assign ovf_err_o     = ovf_q;
  assign unf_err_o     = unf_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_we_o      = mem_we_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              clear;
  logic              clr_err;
  logic [ADDR_W:0]   count;
  logic              full, empty, ovf_err, unf_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  stack_state_e      state;

  stack_ctrl_if #(.DATA_W(DATA_W)) bus ();

  stack_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctl         (bus),
    .clear_i     (clear),
    .clr_err_i   (clr_err),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .ovf_err_o   (ovf_err),
    .unf_err_o   (unf_err),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata),
    .state_o     (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous RAM model
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Scoreboard
  logic [DATA_W-1:0] exp_q[$];   // expected pop_data in output order
  logic [DATA_W-1:0] model[$];   // reference stack contents, top at back
  int checks   = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (!reset && bus.pop_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_valid_unexpected: got pop_data=%h, expected no pop_valid", bus.pop_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (bus.pop_data !== e) begin
          failures++;
          $display("FAIL pop_data: got %h, expected %h", bus.pop_data, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: ready=%b, expected 1 within 50 cycles", bus.ready);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model.delete();
    @(negedge clk);
  endtask

  // Returns at the negedge of the cycle after acceptance.
  task automatic do_push(input logic [DATA_W-1:0] d);
    wait_ready();
    if (model.size() < DEPTH) model.push_back(d);
    bus.push_req  = 1'b1;
    bus.push_data = d;
    @(negedge clk);
    bus.push_req  = 1'b0;
  endtask

  task automatic do_pop();
    wait_ready();
    if (model.size() > 0) exp_q.push_back(model.pop_back());
    bus.pop_req = 1'b1;
    @(negedge clk);
    bus.pop_req = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== ST_IDLE || count !== '0 || empty !== 1'b1 || full !== 1'b0 ||
        bus.ready !== 1'b1 || bus.pop_valid !== 1'b0 || bus.pop_data !== '0 ||
        ovf_err !== 1'b0 || unf_err !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_values: state=%0d count=%0d empty=%b full=%b ready=%b pv=%b pd=%h ovf=%b unf=%b we=%b addr=%0d wd=%h, expected idle/0/1/0/1/0/00/0/0/0/0/00",
               state, count, empty, full, bus.ready, bus.pop_valid, bus.pop_data,
               ovf_err, unf_err, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_lifo();
    do_push(8'h11);
    do_push(8'h22);
    do_push(8'h33);
    wait_ready();
    checks++;
    if (count !== 6'd3) begin
      failures++;
      $display("FAIL lifo_count_after_push: got %0d, expected 3", count);
    end
    do_pop();
    checks++;
    if (count !== 6'd2) begin
      failures++;
      $display("FAIL pop_count_t1: got %0d, expected 2", count);
    end
    do_pop();
    do_pop();
    wait_ready();
    @(negedge clk);
    checks++;
    if (count !== '0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL lifo_end: count=%0d empty=%b, expected 0 and 1", count, empty);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) do_push(DATA_W'($urandom_range(0, 255)));
    wait_ready();
    checks++;
    if (full !== 1'b1 || count !== 6'd32 || ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL full_state: full=%b count=%0d ovf=%b, expected 1, 32, 0", full, count, ovf_err);
    end
    do_push(8'hEE);
    checks++;
    if (ovf_err !== 1'b1 || mem_we !== 1'b0 || bus.ready !== 1'b1 || count !== 6'd32) begin
      failures++;
      $display("FAIL overflow: ovf=%b we=%b ready=%b count=%0d, expected 1, 0, 1, 32",
               ovf_err, mem_we, bus.ready, count);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL clr_err_ovf: got %b, expected 0", ovf_err);
    end
    for (int i = 0; i < DEPTH; i++) do_pop();
    wait_ready();
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || count !== '0) begin
      failures++;
      $display("FAIL drain_after_full: empty=%b count=%0d, expected 1 and 0", empty, count);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    do_pop();
    checks++;
    if (unf_err !== 1'b1 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL underflow_flag: unf=%b ready=%b, expected 1 and 1", unf_err, bus.ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.pop_data !== '0 || count !== '0) begin
      failures++;
      $display("FAIL underflow_data: pop_data=%h count=%0d, expected 00 and 0", bus.pop_data, count);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (unf_err !== 1'b0) begin
      failures++;
      $display("FAIL clr_err_unf: got %b, expected 0", unf_err);
    end
  endtask

  task automatic test_simultaneous();
    do_push(8'h05);
    wait_ready();
    model.push_back(8'hAA);
    exp_q.push_back(model.pop_back());
    bus.push_req  = 1'b1;
    bus.push_data = 8'hAA;
    bus.pop_req   = 1'b1;
    @(negedge clk);
    bus.push_req = 1'b0;
    checks++;
    if (state !== ST_PUSH_WR || mem_we !== 1'b1 || mem_addr !== 5'd1) begin
      failures++;
      $display("FAIL push_priority: state=%0d we=%b addr=%0d, expected PUSH_WR(1), 1, 1",
               state, mem_we, mem_addr);
    end
    wait_ready();
    checks++;
    if (count !== 6'd2) begin
      failures++;
      $display("FAIL simul_count_after_push: got %0d, expected 2", count);
    end
    @(negedge clk);
    bus.pop_req = 1'b0;
    wait_ready();
    @(negedge clk);
    checks++;
    if (count !== 6'd1) begin
      failures++;
      $display("FAIL simul_count_after_pop: got %0d, expected 1", count);
    end
    do_pop();
    wait_ready();
  endtask

  task automatic test_clear();
    apply_reset();
    do_push(8'h01);
    do_push(8'h02);
    do_push(8'h03);
    do_push(8'h04);
    wait_ready();
    bus.pop_req = 1'b1;
    @(negedge clk);
    bus.pop_req = 1'b0;
    checks++;
    if (state !== ST_POP_RD || count !== 6'd3) begin
      failures++;
      $display("FAIL clear_setup: state=%0d count=%0d, expected POP_RD(2), 3", state, count);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model.delete();
    checks++;
    if (count !== '0 || state !== ST_IDLE || bus.ready !== 1'b1 || empty !== 1'b1) begin
      failures++;
      $display("FAIL clear_abort: count=%0d state=%0d ready=%b empty=%b, expected 0, IDLE(0), 1, 1",
               count, state, bus.ready, empty);
    end
    repeat (3) @(negedge clk);
    do_push(8'h77);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 8'h77) begin
      failures++;
      $display("FAIL push_after_clear: we=%b addr=%0d wdata=%h, expected 1, 0, 77",
               mem_we, mem_addr, mem_wdata);
    end
    do_pop();
    wait_ready();
  endtask

  task automatic test_reset_mid_push();
    do_push(8'h5A);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== ST_IDLE || count !== '0 || mem_we !== 1'b0 || bus.ready !== 1'b1 ||
        mem_addr !== '0 || mem_wdata !== '0 || bus.pop_data !== '0 || ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_push: state=%0d count=%0d we=%b ready=%b addr=%0d wd=%h pd=%h ovf=%b, expected reset values",
               state, count, mem_we, bus.ready, mem_addr, mem_wdata, bus.pop_data, ovf_err);
    end
    reset = 1'b0;
    exp_q.delete();
    model.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || count !== '0) begin
        failures++;
        $display("FAIL post_reset_idle: we=%b count=%0d, expected 0 and 0", mem_we, count);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    clr_err       = 1'b0;
    bus.push_req  = 1'b0;
    bus.push_data = '0;
    bus.pop_req   = 1'b0;
    test_reset();
    test_lifo();
    test_full();
    test_underflow();
    test_simultaneous();
    test_clear();
    test_reset_mid_push();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_pops: %0d expected pops never produced, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
